// File: rtl/fsk2_bit_scheduler.sv
// -----------------------------------------------------------------------------
// fsk2_bit_scheduler
//
// Upstream control stage of the FSK2 transmitter. Accepts data words over a
// valid/ready handshake, serializes them bit by bit (each bit held for
// BIT_CYCLES clocks), drives the two-tone mux select, and fires a one-clock
// phase-restart pulse at the DDS that generates the tone of each new bit.
//
// Handshake: a word is accepted at a rising edge of sys_clk where data_valid
// and data_ready are both high. data_ready is combinational: high in IDLE, and
// in SEND only on the final clock of the final bit, so a waiting word follows
// the current one with zero gap. data_in is sampled only on accept.
//
// Ports:
//   sys_clk     in   system clock
//   sys_rst_n   in   asynchronous active-low reset
//   data_in     in   [DATA_W] word to transmit
//   data_valid  in   upstream has a word
//   data_ready  out  block can accept a word this cycle
//   tog_f0      out  one-clock restart pulse for the f0 DDS
//   tog_f1      out  one-clock restart pulse for the f1 DDS
//   sel_f1      out  tone mux select (1 = f1, 0 = f0)
//   bit_out     out  bit currently on air
//   busy        out  a word is being transmitted (also exposes the FSM state)
//   frame_done  out  one-clock pulse after a word's last bit ends
// -----------------------------------------------------------------------------
module fsk2_bit_scheduler #(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 500,
    parameter int MSB_FIRST  = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              tog_f0,
    output logic              tog_f1,
    output logic              sel_f1,
    output logic              bit_out,
    output logic              busy,
    output logic              frame_done
);

    localparam int CYC_W = $clog2(BIT_CYCLES);
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CYC_W-1:0]  cyc_cnt_q, cyc_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              tog_f0_q, tog_f0_d;
    logic              tog_f1_q, tog_f1_d;
    logic              frame_done_q, frame_done_d;

    logic              last_cyc;
    logic              last_bit;
    logic              word_end;
    logic              accept;
    logic [DATA_W-1:0] shifted;
    logic              cur_bit;

    // The bit on air is always the end of the shift register nearest the
    // output; which end depends on MSB_FIRST.
    function automatic logic head_bit(input logic [DATA_W-1:0] v);
        return (MSB_FIRST != 0) ? v[DATA_W-1] : v[0];
    endfunction

    always_comb begin
        last_cyc   = (cyc_cnt_q == CYC_LAST);
        last_bit   = (bit_cnt_q == BIT_LAST);
        word_end   = (state_q == SEND) && last_cyc && last_bit;
        data_ready = (state_q == IDLE) || word_end;
        accept     = data_valid && data_ready;
        shifted    = (MSB_FIRST != 0) ? (shift_q << 1) : (shift_q >> 1);
        cur_bit    = head_bit(shift_q);
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cyc_cnt_d    = cyc_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        tog_f0_d     = 1'b0;
        tog_f1_d     = 1'b0;
        // Same condition for back-to-back and return-to-idle endings.
        frame_done_d = word_end;

        if (accept) begin
            // Covers both IDLE->SEND and the zero-gap reload at word end.
            state_d   = SEND;
            shift_d   = data_in;
            cyc_cnt_d = '0;
            bit_cnt_d = '0;
            tog_f1_d  = head_bit(data_in);
            tog_f0_d  = ~head_bit(data_in);
        end else begin
            case (state_q)
                SEND: begin
                    if (last_cyc) begin
                        cyc_cnt_d = '0;
                        if (last_bit) begin
                            state_d   = IDLE;
                            shift_d   = '0;
                            bit_cnt_d = '0;
                        end else begin
                            shift_d   = shifted;
                            bit_cnt_d = bit_cnt_q + 1'b1;
                            // Every bit restarts its tone, even a repeat.
                            tog_f1_d  = head_bit(shifted);
                            tog_f0_d  = ~head_bit(shifted);
                        end
                    end else begin
                        cyc_cnt_d = cyc_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            cyc_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            tog_f0_q     <= 1'b0;
            tog_f1_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cyc_cnt_q    <= cyc_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            tog_f0_q     <= tog_f0_d;
            tog_f1_q     <= tog_f1_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Outputs come straight from flops (shift register is cleared in IDLE,
    // the gating with busy just makes the idle value explicit).
    assign busy       = (state_q == SEND);
    assign bit_out    = busy & cur_bit;
    assign sel_f1     = bit_out;
    assign tog_f0     = tog_f0_q;
    assign tog_f1     = tog_f1_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fsk2_bit_scheduler.sv
// -----------------------------------------------------------------------------
// tb_fsk2_bit_scheduler
//
// Two instances share stimulus: u_dut_msb (MSB first) and u_dut_lsb (LSB
// first), both DATA_W=8, BIT_CYCLES=4. A word-level model tracks, per
// instance, the word on air and how many clocks have passed since it was
// accepted; expected outputs are derived from that with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_fsk2_bit_scheduler;

  localparam int DW = 8;
  localparam int BC = 4;
  localparam int N  = DW * BC;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] data_in = '0;
  logic          data_valid = 1'b0;

  logic ready_w[2];
  logic tf0_w[2];
  logic tf1_w[2];
  logic sel_w[2];
  logic bit_w[2];
  logic busy_w[2];
  logic fd_w[2];

  fsk2_bit_scheduler #(.DATA_W(DW), .BIT_CYCLES(BC), .MSB_FIRST(1)) u_dut_msb (
    .sys_clk(clk), .sys_rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .data_ready(ready_w[0]), .tog_f0(tf0_w[0]), .tog_f1(tf1_w[0]),
    .sel_f1(sel_w[0]), .bit_out(bit_w[0]), .busy(busy_w[0]), .frame_done(fd_w[0])
  );

  fsk2_bit_scheduler #(.DATA_W(DW), .BIT_CYCLES(BC), .MSB_FIRST(0)) u_dut_lsb (
    .sys_clk(clk), .sys_rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .data_ready(ready_w[1]), .tog_f0(tf0_w[1]), .tog_f1(tf1_w[1]),
    .sel_f1(sel_w[1]), .bit_out(bit_w[1]), .busy(busy_w[1]), .frame_done(fd_w[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h", nm, act, exp);
    end
  endtask

  // Bit on air during clock k (1..N) after the accept edge.
  function automatic bit exp_bit(input logic [DW-1:0] w, input int k, input bit msb);
    int i;
    i = (k - 1) / BC;
    return msb ? w[DW-1-i] : w[i];
  endfunction

  // word-level model
  bit            m_busy[2];
  logic [DW-1:0] m_word[2];
  int            m_k[2];
  bit            m_fd[2];
  bit            exp_ready = 1'b1;

  // event logs (absolute spec-cycle numbers)
  logic [31:0] tf1_q0[$];
  logic [31:0] tf0_q0[$];
  logic [31:0] fd_q0[$];
  logic [31:0] tf1_q1[$];
  logic [31:0] tf0_q1[$];

  task automatic clear_logs();
    tf1_q0.delete(); tf0_q0.delete(); fd_q0.delete();
    tf1_q1.delete(); tf0_q1.delete();
  endtask

  // scoreboard / compare process: outputs are stable here, inputs too
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int u = 0; u < 2; u++) begin
        m_busy[u] = 1'b0;
        m_k[u]    = 0;
        m_fd[u]   = 1'b0;
      end
    end
    for (int u = 0; u < 2; u++) begin
      bit eb;
      bit first;
      eb    = m_busy[u] ? exp_bit(m_word[u], m_k[u], (u == 0)) : 1'b0;
      first = m_busy[u] && (((m_k[u] - 1) % BC) == 0);
      chk($sformatf("u%0d sel_f1 cyc %0d", u, cyc), sel_w[u], eb);
      chk($sformatf("u%0d bit_out cyc %0d", u, cyc), bit_w[u], eb);
      chk($sformatf("u%0d tog_f1 cyc %0d", u, cyc), tf1_w[u], first && eb);
      chk($sformatf("u%0d tog_f0 cyc %0d", u, cyc), tf0_w[u], first && !eb);
      chk($sformatf("u%0d busy cyc %0d", u, cyc), busy_w[u], m_busy[u]);
      chk($sformatf("u%0d frame_done cyc %0d", u, cyc), fd_w[u], m_fd[u]);
      if (rst_n)
        chk($sformatf("u%0d data_ready cyc %0d", u, cyc), ready_w[u],
            !m_busy[u] || (m_k[u] == N));
    end
    if (tf1_w[0]) tf1_q0.push_back(cyc + 1);
    if (tf0_w[0]) tf0_q0.push_back(cyc + 1);
    if (fd_w[0])  fd_q0.push_back(cyc + 1);
    if (tf1_w[1]) tf1_q1.push_back(cyc + 1);
    if (tf0_w[1]) tf0_q1.push_back(cyc + 1);

    exp_ready = !m_busy[0] || (m_k[0] == N);
    if (rst_n) begin
      for (int u = 0; u < 2; u++) begin
        bit rdy;
        rdy     = !m_busy[u] || (m_k[u] == N);
        m_fd[u] = m_busy[u] && (m_k[u] == N);
        if (data_valid && rdy) begin
          m_busy[u] = 1'b1;
          m_word[u] = data_in;
          m_k[u]    = 1;
        end else if (m_busy[u] && m_k[u] < N) begin
          m_k[u] = m_k[u] + 1;
        end else begin
          m_busy[u] = 1'b0;
          m_k[u]    = 0;
        end
      end
    end
  end

  // driver tasks
  task automatic wait_accept(output int t0);
    int n;
    n = 0;
    forever begin
      @(negedge clk); #1;
      if (exp_ready) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout waited %0d cycles expected at most 200", n);
        break;
      end
    end
    @(posedge clk); #1;
    t0 = cyc;
    data_valid = 1'b0;
    data_in = DW'($urandom);
  endtask

  task automatic send_word(input logic [DW-1:0] w, output int t0);
    @(posedge clk); #1;
    data_in = w;
    data_valid = 1'b1;
    wait_accept(t0);
  endtask

  task automatic chk_times(input string nm, input logic [31:0] got[$],
                           input logic [31:0] exp_q[$], input int t0);
    chk({nm, " count"}, got.size(), exp_q.size());
    if (got.size() == exp_q.size())
      for (int i = 0; i < exp_q.size(); i++)
        chk($sformatf("%s[%0d]", nm, i), got[i] - t0, exp_q[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int t0;
    int t1;
    logic [31:0] exp_q[$];

    // model pins
    chk("pin a5 k1", exp_bit(8'hA5, 1, 1'b1), 1);
    chk("pin a5 k5", exp_bit(8'hA5, 5, 1'b1), 0);
    chk("pin a5 k32", exp_bit(8'hA5, 32, 1'b1), 1);
    chk("pin 01 lsb k1", exp_bit(8'h01, 1, 1'b0), 1);
    chk("pin 01 lsb k5", exp_bit(8'h01, 5, 1'b0), 0);

    // reset then idle
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_logs();
    idle(20);
    chk("idle tog_f1 events", tf1_q0.size(), 0);
    chk("idle frame_done events", fd_q0.size(), 0);

    // single word 0xA5
    clear_logs();
    send_word(8'hA5, t0);
    idle(40);
    exp_q = {1, 9, 21, 29};
    chk_times("a5 tog_f1", tf1_q0, exp_q, t0);
    exp_q = {5, 13, 17, 25};
    chk_times("a5 tog_f0", tf0_q0, exp_q, t0);
    exp_q = {33};
    chk_times("a5 frame_done", fd_q0, exp_q, t0);

    // back-to-back 0xFF, 0x00
    clear_logs();
    send_word(8'hFF, t0);
    data_in = 8'h00;
    data_valid = 1'b1;
    wait_accept(t1);
    chk("b2b second accept offset", t1 - t0, 32);
    idle(40);
    chk("b2b tog_f1 count", tf1_q0.size(), 8);
    chk("b2b tog_f0 count", tf0_q0.size(), 8);
    exp_q = {33, 65};
    chk_times("b2b frame_done", fd_q0, exp_q, t0);

    // LSB-first 0x01
    clear_logs();
    send_word(8'h01, t0);
    idle(40);
    exp_q = {1};
    chk_times("lsb 01 tog_f1", tf1_q1, exp_q, t0);
    chk("lsb 01 tog_f0 count", tf0_q1.size(), 7);

    // reset mid-word, then 0x3C
    send_word(8'hA5, t0);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);
    clear_logs();
    send_word(8'h3C, t0);
    idle(40);
    exp_q = {9, 13, 17, 21};
    chk_times("3c tog_f1", tf1_q0, exp_q, t0);
    exp_q = {1, 5, 25, 29};
    chk_times("3c tog_f0", tf0_q0, exp_q, t0);

    // input noise while busy
    clear_logs();
    send_word(8'hA5, t0);
    for (int i = 0; i < 28; i++) begin
      @(posedge clk); #1;
      data_in = DW'($urandom);
      data_valid = 1'($urandom_range(0, 1));
    end
    data_valid = 1'b0;
    idle(10);
    exp_q = {1, 9, 21, 29};
    chk_times("noise tog_f1", tf1_q0, exp_q, t0);

    // random words with random gaps
    for (int i = 0; i < 12; i++) begin
      send_word(DW'($urandom), t0);
      if ($urandom_range(0, 2) == 0) begin
        data_in = DW'($urandom);
        data_valid = 1'b1;
        wait_accept(t1);
      end
      idle($urandom_range(0, 3));
    end
    idle(80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
